// File: rtl/axis_frame_arbiter_pkg.sv
// Shared types for the frame arbiter: FSM state encoding and grant-index sizing.
package axis_frame_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit grant index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_frame_arbiter_skid.sv
// Two-entry registered skid buffer: 1-cycle latency, 1 beat/cycle sustained.
// Input ready is simply "not full", so it never depends on i_rdy combinationally.
module axis_skid_buffer #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_vld0;
  logic             r_vld1;
  logic [WIDTH-1:0] r_dat0;
  logic [WIDTH-1:0] r_dat1;
  logic             w_push;
  logic             w_pop;

  assign o_rdy  = ~r_vld1;
  assign o_vld  = r_vld0;
  assign o_dat  = r_dat0;
  assign w_push = i_vld & ~r_vld1;
  assign w_pop  = r_vld0 & i_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      r_dat0 <= '0;
      r_dat1 <= '0;
    end else if (w_pop) begin
      // With the tail occupied the buffer is full, so no push can coincide.
      if (r_vld1) begin
        r_dat0 <= r_dat1;
        r_vld1 <= 1'b0;
      end else if (w_push) begin
        r_dat0 <= i_dat;
      end else begin
        r_vld0 <= 1'b0;
      end
    end else if (w_push) begin
      if (r_vld0) begin
        r_dat1 <= i_dat;
        r_vld1 <= 1'b1;
      end else begin
        r_dat0 <= i_dat;
        r_vld0 <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// N:1 frame-granular AXI-Stream arbiter; grant at the request edge, egress 1 cycle after accept.
// Backpressure: granted port's tready follows the skid buffer's not-full flag only.
module axis_frame_arbiter
  import axis_frame_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int ARB_MODE   = 0,
  localparam int IDX_WIDTH  = idx_width(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            grant_active,
  output logic [IDX_WIDTH-1:0]            grant_index
);

  arb_state_e             r_state;
  logic                   r_grant_active;
  logic [IDX_WIDTH-1:0]   r_grant_index;
  logic [IDX_WIDTH-1:0]   r_rr_ptr;

  logic                   w_sel_vld;
  logic                   w_sel_last;
  logic [DATA_WIDTH-1:0]  w_sel_dat;
  logic                   w_skid_rdy;
  logic                   w_accept;
  logic [IDX_WIDTH-1:0]   w_winner;
  logic [DATA_WIDTH:0]    w_skid_out;
  logic [NUM_PORTS-1:0]   w_tready;

  // Masked priority encoder: ports at or above the pointer first, then wrap to the full set.
  function automatic logic [IDX_WIDTH-1:0] f_pick(
    input logic [NUM_PORTS-1:0] req,
    input logic [IDX_WIDTH-1:0] ptr
  );
    logic [NUM_PORTS-1:0] upper;
    logic [NUM_PORTS-1:0] cand;
    logic [IDX_WIDTH-1:0] sel;
    for (int i = 0; i < NUM_PORTS; i++) upper[i] = (i >= int'(ptr));
    cand = ((ARB_MODE == 0) && |(req & upper)) ? (req & upper) : req;
    sel  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (cand[i]) sel = IDX_WIDTH'(i);
    end
    return sel;
  endfunction

  assign w_winner   = f_pick(s_axis_tvalid, r_rr_ptr);
  assign w_sel_vld  = (r_state == ST_BUSY) & s_axis_tvalid[r_grant_index];
  assign w_sel_last = s_axis_tlast[r_grant_index];
  assign w_sel_dat  = s_axis_tdata[r_grant_index*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept   = w_sel_vld & w_skid_rdy;

  always_comb begin
    w_tready = '0;
    if (r_state == ST_BUSY) w_tready[r_grant_index] = w_skid_rdy;
  end

  assign s_axis_tready = w_tready;
  assign grant_active  = r_grant_active;
  assign grant_index   = r_grant_index;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_grant_active <= 1'b0;
      r_grant_index  <= '0;
      r_rr_ptr       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|s_axis_tvalid) begin
            r_grant_index  <= w_winner;
            r_grant_active <= 1'b1;
            r_state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Fairness pointer moves only when the granted frame completes.
          if (w_accept && w_sel_last) begin
            r_grant_active <= 1'b0;
            r_state        <= ST_IDLE;
            r_rr_ptr       <= (r_grant_index == IDX_WIDTH'(NUM_PORTS - 1)) ?
                              '0 : r_grant_index + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .i_vld (w_sel_vld),
    .o_rdy (w_skid_rdy),
    .i_dat ({w_sel_last, w_sel_dat}),
    .o_vld (m_axis_tvalid),
    .i_rdy (m_axis_tready),
    .o_dat (w_skid_out)
  );

  assign m_axis_tlast = w_skid_out[DATA_WIDTH];
  assign m_axis_tdata = w_skid_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Bench for axis_frame_arbiter: a round-robin and a fixed-priority instance driven
// from per-port beat queues and checked every cycle against a queue-based model.
module tb_axis_frame_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [NP*DW-1:0] s_tdata  [2];
  logic [NP-1:0]    s_tvalid [2];
  logic [NP-1:0]    s_tready [2];
  logic [NP-1:0]    s_tlast  [2];
  logic [DW-1:0]    m_tdata  [2];
  logic             m_tvalid [2];
  logic             m_tready [2];
  logic             m_tlast  [2];
  logic             g_act    [2];
  logic [1:0]       g_idx    [2];

  axis_frame_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ARB_MODE(0)) u_rr (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .s_axis_tlast(s_tlast[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]),
    .grant_active(g_act[0]), .grant_index(g_idx[0])
  );

  axis_frame_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ARB_MODE(1)) u_fp (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .s_axis_tlast(s_tlast[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]),
    .grant_active(g_act[1]), .grant_index(g_idx[1])
  );

  int n_vec;
  int n_err;
  int cyc;

  // Source beats: [9]=idle bubble, [8]=tlast, [7:0]=data. Index = instance*NP + port.
  logic [9:0] src_q [8][$];
  // Reference model: egress buffer contents, grant state and fairness pointer.
  logic [8:0] mf [2][$];
  bit         mbusy [2];
  int         mg [2];
  int         mptr [2];

  int         rdy_mode [2];
  logic [7:0] eg_bytes [2][$];
  int         eg_tags [2][$];
  bit         eg_sof [2];
  int         first_out [2];
  logic [7:0] last_tl_dat [2];
  bit         chk_stall;
  int         stall_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input int d, input string pfx);
    chk({pfx, "_s_tready"}, 32'(s_tready[d]), 32'd0);
    chk({pfx, "_m_tvalid"}, 32'(m_tvalid[d]), 32'd0);
    chk({pfx, "_m_tlast"},  32'(m_tlast[d]),  32'd0);
    chk({pfx, "_m_tdata"},  32'(m_tdata[d]),  32'd0);
    chk({pfx, "_g_act"},    32'(g_act[d]),    32'd0);
    chk({pfx, "_g_idx"},    32'(g_idx[d]),    32'd0);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mbusy[d] = 1'b0;
      mg[d]    = 0;
      mptr[d]  = 0;
      mf[d].delete();
    end
  endtask

  task automatic clear_logs(input int d);
    eg_bytes[d].delete();
    eg_tags[d].delete();
    eg_sof[d]    = 1'b1;
    first_out[d] = -1;
  endtask

  task automatic drive_inputs();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        int k = d * NP + p;
        if (src_q[k].size() > 0 && !src_q[k][0][9]) begin
          s_tvalid[d][p]         = 1'b1;
          s_tlast[d][p]          = src_q[k][0][8];
          s_tdata[d][p*DW +: DW] = src_q[k][0][7:0];
        end else begin
          s_tvalid[d][p]         = 1'b0;
          s_tlast[d][p]          = 1'($urandom);
          s_tdata[d][p*DW +: DW] = 8'($urandom);
        end
      end
      case (rdy_mode[d])
        0:       m_tready[d] = 1'b1;
        1:       m_tready[d] = ($urandom_range(0, 3) != 0);
        2:       m_tready[d] = (((cyc / 3) % 2) == 0);
        default: m_tready[d] = 1'b0;
      endcase
    end
  endtask

  task automatic push_frame(input int d, input int p, input int len, input int base,
                            input int gap_at, input int gap_len);
    int k = d * NP + p;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) begin
        for (int j = 0; j < gap_len; j++) src_q[k].push_back(10'h200);
      end
      src_q[k].push_back({1'b0, 1'(i == len - 1), 8'(base + i)});
    end
  endtask

  task automatic model_check(input int d);
    logic [3:0] exp_rdy;
    exp_rdy = (mbusy[d] && mf[d].size() < 2) ? 4'(1 << mg[d]) : 4'b0;
    chk($sformatf("i%0d_s_tready", d), 32'(s_tready[d]), 32'(exp_rdy));
    chk($sformatf("i%0d_m_tvalid", d), 32'(m_tvalid[d]), 32'(mf[d].size() > 0));
    if (mf[d].size() > 0) begin
      chk($sformatf("i%0d_m_tdata", d), 32'(m_tdata[d]), 32'(mf[d][0][7:0]));
      chk($sformatf("i%0d_m_tlast", d), 32'(m_tlast[d]), 32'(mf[d][0][8]));
    end
    chk($sformatf("i%0d_g_act", d), 32'(g_act[d]), 32'(mbusy[d]));
    chk($sformatf("i%0d_g_idx", d), 32'(g_idx[d]), 32'(mg[d]));
  endtask

  task automatic model_step(input int d);
    int sz;
    int w;
    logic [8:0] beat;
    sz = mf[d].size();
    if (sz > 0 && m_tready[d]) void'(mf[d].pop_front());
    if (mbusy[d]) begin
      if (s_tvalid[d][mg[d]] && sz < 2) begin
        beat = {s_tlast[d][mg[d]], s_tdata[d][mg[d]*DW +: DW]};
        mf[d].push_back(beat);
        if (beat[8]) begin
          mbusy[d] = 1'b0;
          mptr[d]  = (mg[d] + 1) % NP;
        end
      end
    end else if (s_tvalid[d] != '0) begin
      w = -1;
      for (int i = 0; i < NP; i++) begin
        int p = (d == 1) ? i : (mptr[d] + i) % NP;
        if (w < 0 && s_tvalid[d][p]) w = p;
      end
      mbusy[d] = 1'b1;
      mg[d]    = w;
    end
  endtask

  task automatic monitor(input int d);
    if (m_tvalid[d] && first_out[d] < 0) first_out[d] = cyc;
    if (m_tvalid[d] && m_tready[d]) begin
      eg_bytes[d].push_back(m_tdata[d]);
      if (eg_sof[d]) eg_tags[d].push_back(int'(m_tdata[d][7:4]));
      eg_sof[d] = m_tlast[d];
      if (m_tlast[d]) last_tl_dat[d] = m_tdata[d];
    end
    if (d == 0 && chk_stall) begin
      stall_run = m_tready[0] ? 0 : stall_run + 1;
      if (stall_run >= 3) chk("bp_stall_tready", 32'(s_tready[0]), 32'd0);
    end
  endtask

  task automatic cycle();
    bit acc [8];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      monitor(d);
      model_check(d);
    end
    for (int k = 0; k < 8; k++) acc[k] = s_tvalid[k/NP][k%NP] && s_tready[k/NP][k%NP];
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      if (src_q[k].size() > 0 && (src_q[k][0][9] || acc[k])) void'(src_q[k].pop_front());
    end
    cyc++;
    drive_inputs();
  endtask

  task automatic run_until(input int d, input int n, input int maxc, input string tag);
    int c = 0;
    while (eg_bytes[d].size() < n && c < maxc) begin
      cycle();
      c++;
    end
    chk(tag, 32'(eg_bytes[d].size()), 32'(n));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_in;
    int bad;
    int sent [2];
    n_vec = 0; n_err = 0; cyc = 0;
    rdy_mode[0] = 0; rdy_mode[1] = 0;
    chk_stall = 1'b0; stall_run = 0;
    rstn = 1'b1;
    model_reset();
    clear_logs(0);
    clear_logs(1);
    drive_inputs();
    #1 rstn = 1'b0;
    #2;
    chk_reset_vals(0, "rst0");
    chk_reset_vals(1, "rst1");
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;

    // Round-robin fairness: all four ports back-to-back, tag = port id in the high nibble.
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < NP; p++) push_frame(0, p, 8, p << 4, -1, 0);
    drive_inputs();
    run_until(0, 128, 400, "rr_done");
    for (int i = 0; i < 16; i++)
      chk($sformatf("rr_order%0d", i), 32'((eg_tags[0].size() > i) ? eg_tags[0][i] : 99), 32'(i % 4));

    // Single source on port 2: 60 bytes 0x00..0x3B.
    clear_logs(0);
    push_frame(0, 2, 60, 0, -1, 0);
    drive_inputs();
    t_in = cyc;
    run_until(0, 60, 300, "ss_done");
    chk("ss_latency", 32'(first_out[0] - t_in), 32'd2);
    bad = 0;
    for (int i = 0; i < 60; i++)
      if (i >= eg_bytes[0].size() || eg_bytes[0][i] !== 8'(i)) bad++;
    chk("ss_bytes_bad", 32'(bad), 32'd0);
    chk("ss_tlast_byte", 32'(last_tl_dat[0]), 32'h3B);
    chk("ss_grant_idx", 32'(g_idx[0]), 32'd2);

    // Fixed priority: ports 1 and 3 both offering; port 3 only after port 1 runs dry.
    for (int f = 0; f < 3; f++) begin
      push_frame(1, 1, 6, 8'h10, -1, 0);
      push_frame(1, 3, 6, 8'h30, -1, 0);
    end
    drive_inputs();
    run_until(1, 36, 300, "fp_done");
    for (int i = 0; i < 6; i++)
      chk($sformatf("fp_order%0d", i), 32'((eg_tags[1].size() > i) ? eg_tags[1][i] : 99), (i < 3) ? 32'd1 : 32'd3);

    // Backpressure: downstream ready toggles every 3 cycles during a 64-byte frame.
    clear_logs(0);
    rdy_mode[0] = 2;
    chk_stall   = 1'b1;
    stall_run   = 0;
    push_frame(0, 0, 64, 0, -1, 0);
    drive_inputs();
    run_until(0, 64, 600, "bp_done");
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (i >= eg_bytes[0].size() || eg_bytes[0][i] !== 8'(i)) bad++;
    chk("bp_bytes_bad", 32'(bad), 32'd0);
    chk_stall   = 1'b0;
    rdy_mode[0] = 0;
    drive_inputs();

    // Mid-frame bubble on port 0 while port 1 requests.
    clear_logs(0);
    push_frame(0, 0, 16, 8'h00, 6, 5);
    drive_inputs();
    repeat (3) cycle();
    push_frame(0, 1, 8, 8'h10, -1, 0);
    drive_inputs();
    run_until(0, 24, 200, "bub_done");
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (i >= eg_bytes[0].size() || eg_bytes[0][i][7:4] !== 4'd0) bad++;
    chk("bub_p0_bytes_bad", 32'(bad), 32'd0);
    chk("bub_first_tag", 32'((eg_tags[0].size() > 0) ? eg_tags[0][0] : 99), 32'd0);
    chk("bub_second_tag", 32'((eg_tags[0].size() > 1) ? eg_tags[0][1] : 99), 32'd1);

    // Async reset during beat 10 of a 40-beat frame, with the pointer parked at 3.
    clear_logs(0);
    push_frame(0, 2, 4, 8'h20, -1, 0);
    drive_inputs();
    run_until(0, 4, 100, "rst_setup");
    clear_logs(0);
    push_frame(0, 2, 40, 8'h40, -1, 0);
    drive_inputs();
    run_until(0, 10, 100, "rst_pre");
    #2 rstn = 1'b0;
    #1;
    chk_reset_vals(0, "midrst");
    model_reset();
    for (int k = 0; k < 8; k++) src_q[k].delete();
    drive_inputs();
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    clear_logs(0);
    push_frame(0, 1, 4, 8'h10, -1, 0);
    push_frame(0, 3, 4, 8'h30, -1, 0);
    drive_inputs();
    run_until(0, 8, 100, "rst_post");
    chk("rst_post_first", 32'((eg_tags[0].size() > 0) ? eg_tags[0][0] : 99), 32'd1);
    chk("rst_post_second", 32'((eg_tags[0].size() > 1) ? eg_tags[0][1] : 99), 32'd3);

    // Randomized traffic on both instances: random ports, lengths 1..12, bubbles, stalls.
    clear_logs(0);
    clear_logs(1);
    sent[0] = 0; sent[1] = 0;
    rdy_mode[0] = 1; rdy_mode[1] = 1;
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        int d   = int'($urandom_range(0, 1));
        int p   = int'($urandom_range(0, NP - 1));
        int len = int'($urandom_range(1, 12));
        if (src_q[d*NP+p].size() < 40) begin
          push_frame(d, p, len, int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
          sent[d] += len;
        end
      end
      cycle();
    end
    rdy_mode[0] = 0; rdy_mode[1] = 0;
    drive_inputs();
    run_until(0, sent[0], 3000, "rnd_drain0");
    run_until(1, sent[1], 3000, "rnd_drain1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
